// File: rtl/timer_bank.sv
// ---------------------------------------------------------------------------
// timer_bank
//
// Bank of NUM_CH independent up-counting timers on the BusMatrix.
// Each channel has a prescaler (PSC), an auto-reload value (ARR), a counter
// (CNT), a control register (CR: EN, OPM, UIE) and a status register
// (SR: UIF, write-1-to-clear).
//
// Register map at BASE_ADDR + ch*CH_STRIDE + offset:
//   0x00 CR   bit0 EN, bit1 OPM (one-shot), bit2 UIE
//   0x04 PSC  prescaler reload, tick period is PSC+1 cycles
//   0x08 ARR  counter top value, update when CNT==ARR on a tick
//   0x0C CNT  current count, a write loads it and clears the prescaler
//   0x10 SR   bit0 UIF, write 1 to clear
//
// Ports:
//   ACLK, ARESETn       clock, synchronous active-low reset
//   WriteValid/Addr/Data/Strb, SlaverWriteReady
//                       write port, acknowledged one cycle after the request
//   ReadValid/Addr, ReadData, SlaverReadReady
//                       read port, data returned one cycle after the request
//   TimerIrq            per-channel interrupt, UIF & UIE
//   TimerInt            OR of all TimerIrq bits
// ---------------------------------------------------------------------------
module timer_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_5000_0000,
  parameter logic [63:0] CH_STRIDE = 64'h0000_0000_0000_0020
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              WriteValid,
  input  logic [63:0]       WriteAddr,
  input  logic [63:0]       WriteData,
  input  logic [3:0]        WriteStrb,
  output logic              SlaverWriteReady,
  input  logic              ReadValid,
  input  logic [63:0]       ReadAddr,
  output logic [63:0]       ReadData,
  output logic              SlaverReadReady,
  output logic [NUM_CH-1:0] TimerIrq,
  output logic              TimerInt
);

  typedef enum logic [2:0] {
    REG_CR   = 3'd0,
    REG_PSC  = 3'd1,
    REG_ARR  = 3'd2,
    REG_CNT  = 3'd3,
    REG_SR   = 3'd4,
    REG_NONE = 3'd7
  } reg_sel_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] ch;
    reg_sel_e   sel;
  } dec_t;

  // Map a byte address to (channel, register); misaligned, gap and
  // out-of-range addresses come back with hit=0.
  function automatic dec_t decode_addr(input logic [63:0] addr);
    dec_t        d;
    logic [63:0] ch_base;
    d.hit = 1'b0;
    d.ch  = 3'd0;
    d.sel = REG_NONE;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_base = BASE_ADDR + (64'(c) * CH_STRIDE);
      case (addr - ch_base)
        64'h00:  begin d.hit = 1'b1; d.ch = 3'(c); d.sel = REG_CR;  end
        64'h04:  begin d.hit = 1'b1; d.ch = 3'(c); d.sel = REG_PSC; end
        64'h08:  begin d.hit = 1'b1; d.ch = 3'(c); d.sel = REG_ARR; end
        64'h0C:  begin d.hit = 1'b1; d.ch = 3'(c); d.sel = REG_CNT; end
        64'h10:  begin d.hit = 1'b1; d.ch = 3'(c); d.sel = REG_SR;  end
        default: begin end
      endcase
    end
    return d;
  endfunction

  // Merge a 32-bit write into an old value, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
      else         r[b*8 +: 8] = old_val[b*8 +: 8];
    end
    return r;
  endfunction

  // Zero-extended 32-bit view of one channel register.
  function automatic logic [31:0] select_reg(input reg_sel_e         sel,
                                             input logic [2:0]       cr,
                                             input logic [CNT_W-1:0] psc,
                                             input logic [CNT_W-1:0] arr,
                                             input logic [CNT_W-1:0] cnt,
                                             input logic             uif);
    case (sel)
      REG_CR:  return 32'(cr);
      REG_PSC: return 32'(psc);
      REG_ARR: return 32'(arr);
      REG_CNT: return 32'(cnt);
      REG_SR:  return {31'h0, uif};
      default: return 32'h0;
    endcase
  endfunction

  // Channel state
  logic [NUM_CH-1:0]            en_r;
  logic [NUM_CH-1:0]            opm_r;
  logic [NUM_CH-1:0]            uie_r;
  logic [NUM_CH-1:0]            uif_r;
  logic [NUM_CH-1:0][CNT_W-1:0] psc_r;
  logic [NUM_CH-1:0][CNT_W-1:0] arr_r;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_r;
  logic [NUM_CH-1:0][CNT_W-1:0] pre_r;

  // Bus port state
  logic        wr_ack_r;
  logic        rd_ack_r;
  logic [31:0] read_data_r;

  // Decode and per-channel event strobes
  dec_t              rd_dec_s;
  dec_t              wr_dec_s;
  logic [31:0]       rd_val_s;
  logic [31:0]       wr_old_s;
  logic [31:0]       wr_new_s;
  logic [NUM_CH-1:0] wr_hit_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] cnt_wr_s;
  logic [NUM_CH-1:0] sr_clr_s;
  logic [NUM_CH-1:0] upd_s;
  logic              unused_s;

  assign unused_s = ^{WriteData[63:32], wr_new_s};

  // Address decode, read mux and byte-lane merge of the incoming write.
  always_comb begin
    rd_dec_s = decode_addr(ReadAddr);
    wr_dec_s = decode_addr(WriteAddr);
    rd_val_s = 32'h0;
    wr_old_s = 32'h0;
    wr_hit_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_dec_s.hit && (rd_dec_s.ch == 3'(c))) begin
        rd_val_s = select_reg(rd_dec_s.sel, {uie_r[c], opm_r[c], en_r[c]},
                              psc_r[c], arr_r[c], cnt_r[c], uif_r[c]);
      end else begin
        rd_val_s = rd_val_s;
      end
      if (WriteValid && wr_dec_s.hit && (wr_dec_s.ch == 3'(c))) begin
        wr_hit_s[c] = 1'b1;
        // SR is W1C: unstrobed lanes must merge as zeros, never as old ones
        wr_old_s = (wr_dec_s.sel == REG_SR) ? 32'h0 :
                   select_reg(wr_dec_s.sel, {uie_r[c], opm_r[c], en_r[c]},
                              psc_r[c], arr_r[c], cnt_r[c], uif_r[c]);
      end else begin
        wr_old_s = wr_old_s;
      end
    end
    wr_new_s = apply_strb(wr_old_s, WriteData[31:0], WriteStrb);
  end

  // Prescaler tick and update-event detection per channel.
  always_comb begin
    tick_s   = '0;
    cnt_wr_s = '0;
    sr_clr_s = '0;
    upd_s    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick_s[c]   = en_r[c] && (pre_r[c] == psc_r[c]);
      cnt_wr_s[c] = wr_hit_s[c] && (wr_dec_s.sel == REG_CNT);
      sr_clr_s[c] = wr_hit_s[c] && (wr_dec_s.sel == REG_SR) && wr_new_s[0];
      // a software CNT load swallows the update event of the same cycle
      upd_s[c]    = tick_s[c] && (cnt_r[c] == arr_r[c]) && !cnt_wr_s[c];
    end
  end

  // Counting and register writes; software writes come last so they win.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      en_r  <= '0;
      opm_r <= '0;
      uie_r <= '0;
      uif_r <= '0;
      psc_r <= '0;
      arr_r <= '0;
      cnt_r <= '0;
      pre_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick_s[c]) begin
          pre_r[c] <= '0;
          if (cnt_r[c] == arr_r[c]) cnt_r[c] <= '0;
          else                      cnt_r[c] <= cnt_r[c] + CNT_W'(1'b1);
        end else if (en_r[c]) begin
          pre_r[c] <= pre_r[c] + CNT_W'(1'b1);
        end else begin
          pre_r[c] <= pre_r[c];
        end

        // hardware set beats a simultaneous W1C
        if (upd_s[c])         uif_r[c] <= 1'b1;
        else if (sr_clr_s[c]) uif_r[c] <= 1'b0;
        else                  uif_r[c] <= uif_r[c];

        if (upd_s[c] && opm_r[c]) en_r[c] <= 1'b0;
        else                      en_r[c] <= en_r[c];

        if (wr_hit_s[c]) begin
          case (wr_dec_s.sel)
            REG_CR: begin
              en_r[c]  <= wr_new_s[0];
              opm_r[c] <= wr_new_s[1];
              uie_r[c] <= wr_new_s[2];
            end
            REG_PSC: begin
              psc_r[c] <= wr_new_s[CNT_W-1:0];
              pre_r[c] <= '0;
            end
            REG_ARR: arr_r[c] <= wr_new_s[CNT_W-1:0];
            REG_CNT: begin
              cnt_r[c] <= wr_new_s[CNT_W-1:0];
              pre_r[c] <= '0;
            end
            default: begin end
          endcase
        end else begin
          psc_r[c] <= psc_r[c];
        end
      end
    end
  end

  // One-cycle acknowledges and the registered read data.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ack_r    <= 1'b0;
      rd_ack_r    <= 1'b0;
      read_data_r <= 32'h0;
    end else begin
      wr_ack_r    <= WriteValid;
      rd_ack_r    <= ReadValid;
      read_data_r <= ReadValid ? rd_val_s : 32'h0;
    end
  end

  assign SlaverWriteReady = wr_ack_r;
  assign SlaverReadReady  = rd_ack_r;
  assign ReadData         = {32'h0, read_data_r};
  assign TimerIrq         = uif_r & uie_r;
  assign TimerInt         = |TimerIrq;

endmodule

// File: tb/tb_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_timer_bank
//
// Scoreboard bench for timer_bank. A reference model tracks each channel as
// "anchor value + elapsed enabled cycles" and derives CNT, the prescaler
// phase and the number of update events with plain division/modulo. Reads
// push their expected value into a queue; a negedge monitor pops and
// compares whenever SlaverReadReady is presented, and also compares the
// acknowledges and interrupt outputs every cycle.
// ---------------------------------------------------------------------------
module tb_timer_bank;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam logic [63:0] BASE   = 64'h0000_0000_5000_0000;
  localparam logic [63:0] STRIDE = 64'h0000_0000_0000_0020;
  localparam longint      MASK   = 64'h0000_0000_FFFF_FFFF;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              WriteValid = 1'b0;
  logic [63:0]       WriteAddr = 64'h0;
  logic [63:0]       WriteData = 64'h0;
  logic [3:0]        WriteStrb = 4'h0;
  logic              SlaverWriteReady;
  logic              ReadValid = 1'b0;
  logic [63:0]       ReadAddr = 64'h0;
  logic [63:0]       ReadData;
  logic              SlaverReadReady;
  logic [NUM_CH-1:0] TimerIrq;
  logic              TimerInt;

  always #5 ACLK = ~ACLK;

  timer_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_ADDR(BASE), .CH_STRIDE(STRIDE)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .WriteValid(WriteValid), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .WriteStrb(WriteStrb), .SlaverWriteReady(SlaverWriteReady),
    .ReadValid(ReadValid), .ReadAddr(ReadAddr), .ReadData(ReadData),
    .SlaverReadReady(SlaverReadReady), .TimerIrq(TimerIrq), .TimerInt(TimerInt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per channel, value at the last anchor plus elapsed
  // enabled cycles since then.
  longint m_psc[NUM_CH], m_arr[NUM_CH], m_cnt0[NUM_CH], m_pre0[NUM_CH], m_el[NUM_CH];
  bit     m_en[NUM_CH], m_opm[NUM_CH], m_uie[NUM_CH], m_uif[NUM_CH];
  bit     started = 1'b0;
  bit     exp_rrdy = 1'b0;
  bit     exp_wrdy = 1'b0;
  logic [31:0] exp_q[$];
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  // model scratch, used only by the model process
  int          s_wc, s_wr;
  logic [31:0] s_wold, s_wnew;
  longint      s_n0;
  bit          s_upd;

  function automatic longint ticks_of(int c);
    return (m_pre0[c] + m_el[c]) / (m_psc[c] + 1);
  endfunction

  function automatic longint pre_of(int c);
    return (m_pre0[c] + m_el[c]) % (m_psc[c] + 1);
  endfunction

  // tick number (1-based) of the first update after the anchor
  function automatic longint first_upd(int c);
    return ((m_arr[c] - m_cnt0[c]) & MASK) + 1;
  endfunction

  function automatic longint nupd_of(int c);
    longint t = ticks_of(c);
    longint f = first_upd(c);
    if (t < f) return 0;
    return 1 + (t - f) / (m_arr[c] + 1);
  endfunction

  function automatic longint cnt_of(int c);
    longint t = ticks_of(c);
    longint f = first_upd(c);
    if (t < f) return (m_cnt0[c] + t) & MASK;
    return (t - f) % (m_arr[c] + 1);
  endfunction

  function automatic int mdec_ch(logic [63:0] addr);
    logic [63:0] off;
    if (addr < BASE) return -1;
    off = addr - BASE;
    if (off / STRIDE >= 64'(NUM_CH)) return -1;
    case (off % STRIDE)
      64'h0, 64'h4, 64'h8, 64'hC, 64'h10: return int'(off / STRIDE);
      default: return -1;
    endcase
  endfunction

  function automatic int mdec_reg(logic [63:0] addr);
    return int'((addr - BASE) % STRIDE);
  endfunction

  function automatic logic [31:0] model_reg(logic [63:0] addr);
    int c = mdec_ch(addr);
    if (c < 0) return 32'h0;
    case (mdec_reg(addr))
      0:       return {29'h0, m_uie[c], m_opm[c], m_en[c]};
      4:       return 32'(m_psc[c]);
      8:       return 32'(m_arr[c]);
      12:      return 32'(cnt_of(c));
      16:      return {31'h0, m_uif[c]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] model_irq();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_uif[c] & m_uie[c];
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update at each active edge.
  always @(posedge ACLK) begin
    if (!ARESETn) begin
      started  = 1'b1;
      exp_rrdy = 1'b0;
      exp_wrdy = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_psc[c] = 0; m_arr[c] = 0; m_cnt0[c] = 0; m_pre0[c] = 0; m_el[c] = 0;
        m_en[c] = 1'b0; m_opm[c] = 1'b0; m_uie[c] = 1'b0; m_uif[c] = 1'b0;
      end
    end else begin
      // reads and write merges see the state before this edge
      if (ReadValid) exp_q.push_back(ovr_en ? ovr_val : model_reg(ReadAddr));
      exp_rrdy = ReadValid;
      exp_wrdy = WriteValid;
      s_wc   = WriteValid ? mdec_ch(WriteAddr) : -1;
      s_wr   = mdec_reg(WriteAddr);
      s_wold = (s_wr == 16) ? 32'h0 : model_reg(WriteAddr);
      s_wnew = merge(s_wold, WriteData[31:0], WriteStrb);
      for (int c = 0; c < NUM_CH; c++) begin
        s_upd = 1'b0;
        if (m_en[c]) begin
          s_n0 = nupd_of(c);
          m_el[c]++;
          s_upd = nupd_of(c) > s_n0;
        end
        if (s_wc == c && s_wr == 12) s_upd = 1'b0;
        if (s_upd) begin
          m_uif[c] = 1'b1;
          if (m_opm[c]) begin
            m_cnt0[c] = cnt_of(c); m_pre0[c] = pre_of(c); m_el[c] = 0;
            m_en[c] = 1'b0;
          end
        end
        if (s_wc == c) begin
          m_cnt0[c] = cnt_of(c); m_pre0[c] = pre_of(c); m_el[c] = 0;
          case (s_wr)
            0:  begin m_en[c] = s_wnew[0]; m_opm[c] = s_wnew[1]; m_uie[c] = s_wnew[2]; end
            4:  begin m_psc[c] = longint'(s_wnew); m_pre0[c] = 0; end
            8:  m_arr[c] = longint'(s_wnew);
            12: begin m_cnt0[c] = longint'(s_wnew); m_pre0[c] = 0; end
            16: if (s_wnew[0] && !s_upd) m_uif[c] = 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: acknowledges, interrupts, and scoreboard pop on read data.
  always @(negedge ACLK) begin
    logic [31:0] e;
    if (started) begin
      check("read_ready", SlaverReadReady, exp_rrdy);
      check("write_ready", SlaverWriteReady, exp_wrdy);
      check("timer_irq", TimerIrq, model_irq());
      check("timer_int", TimerInt, |model_irq());
      if (SlaverReadReady === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got data %0h with no read pending", ReadData);
        end else begin
          e = exp_q.pop_front();
          check("read_data", ReadData, {32'h0, e});
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic bus_cycle(bit dw, logic [63:0] wa, logic [31:0] wd, logic [3:0] ws,
                           bit dr, logic [63:0] ra, bit oe, logic [31:0] ov);
    WriteValid = dw; WriteAddr = wa; WriteData = {32'h0, wd}; WriteStrb = ws;
    ReadValid = dr; ReadAddr = ra; ovr_en = oe; ovr_val = ov;
    @(posedge ACLK);
    #1;
    WriteValid = 1'b0; ReadValid = 1'b0; ovr_en = 1'b0;
  endtask

  function automatic logic [63:0] ra(int ch, int off);
    return BASE + 64'(ch) * STRIDE + 64'(off);
  endfunction

  task automatic wr(int ch, int off, logic [31:0] d, logic [3:0] s = 4'hF);
    bus_cycle(1'b1, ra(ch, off), d, s, 1'b0, 64'h0, 1'b0, 32'h0);
  endtask

  task automatic rd(int ch, int off, bit oe = 1'b0, logic [31:0] ov = 32'h0);
    bus_cycle(1'b0, 64'h0, 32'h0, 4'h0, 1'b1, ra(ch, off), oe, ov);
  endtask

  task automatic read_all(bit expect_zero);
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < 5; r++) rd(c, r * 4, expect_zero, 32'h0);
  endtask

  function automatic logic [63:0] rand_addr();
    int k = $urandom_range(0, 9);
    int offs[5] = '{0, 4, 8, 12, 16};
    if (k < 7) return ra($urandom_range(0, NUM_CH - 1), offs[$urandom_range(0, 4)]);
    if (k == 7) return ra($urandom_range(NUM_CH, 7), offs[$urandom_range(0, 4)]);
    if (k == 8) return ra($urandom_range(0, NUM_CH - 1), 20 + 2 * $urandom_range(0, 5));
    return 64'h0;
  endfunction

  function automatic logic [31:0] rand_data(logic [63:0] a);
    case (mdec_reg(a))
      0:  return 32'($urandom_range(0, 7));
      4:  return 32'($urandom_range(0, 3));
      8:  return 32'($urandom_range(0, 15));
      12: return 32'($urandom_range(0, 20));
      16: return 32'($urandom_range(0, 1));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [63:0] a;
    logic [3:0]  s;
    int          op;

    // reset, then every register reads 0
    ARESETn = 1'b0;
    idle(3);
    ARESETn = 1'b1;
    check("reset_readdata", ReadData, 64'h0);
    read_all(1'b1);

    // ch0: periodic update every 5 cycles with the interrupt enabled
    wr(0, 4, 32'h0);
    wr(0, 8, 32'h4);
    wr(0, 0, 32'h5);
    idle(12);
    wr(0, 16, 32'h1);
    idle(12);

    // ch1: one-shot, 12 cycles to the single update, UIE off
    wr(1, 4, 32'h3);
    wr(1, 8, 32'h2);
    wr(1, 0, 32'h3);
    idle(20);
    rd(1, 0, 1'b1, 32'h2);
    rd(1, 12, 1'b1, 32'h0);
    rd(1, 16, 1'b1, 32'h1);

    // ch2: update every cycle, W1C every cycle, set wins
    wr(2, 8, 32'h0);
    wr(2, 0, 32'h1);
    idle(2);
    for (int i = 0; i < 10; i++)
      bus_cycle(1'b1, ra(2, 16), 32'h1, 4'hF, 1'b1, ra(2, 16), 1'b1, 32'h1);

    // ch3: CNT load at 6 (update two ticks later), then stop at 3
    wr(3, 8, 32'd10);
    wr(3, 0, 32'h1);
    idle(6);
    wr(3, 12, 32'd9);
    idle(4);
    wr(3, 0, 32'h0);
    idle(20);
    rd(3, 12, 1'b1, 32'd3);
    rd(3, 16, 1'b1, 32'h1);
    // same-cycle read of the register being written returns the old value
    bus_cycle(1'b1, ra(3, 8), 32'd5, 4'hF, 1'b1, ra(3, 8), 1'b1, 32'd10);
    rd(3, 8, 1'b1, 32'd5);

    // byte strobe and a write beyond the last channel
    wr(0, 8, 32'hFFFF_FFFF, 4'h1);
    rd(0, 8, 1'b1, 32'h0000_00FF);
    wr(NUM_CH, 0, 32'hFFFF, 4'hF);
    read_all(1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 3);
      a  = rand_addr();
      s  = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
      case (op)
        0: bus_cycle(1'b1, a, rand_data(a), s, 1'b0, 64'h0, 1'b0, 32'h0);
        1: bus_cycle(1'b0, 64'h0, 32'h0, 4'h0, 1'b1, a, 1'b0, 32'h0);
        2: bus_cycle(1'b1, a, rand_data(a), s, 1'b1, rand_addr(), 1'b0, 32'h0);
        default: idle($urandom_range(1, 4));
      endcase
    end
    read_all(1'b0);

    // reset in the middle of counting
    wr(0, 4, 32'h0);
    wr(0, 8, 32'd50);
    wr(0, 0, 32'h5);
    idle(7);
    ARESETn = 1'b0;
    idle(1);
    ARESETn = 1'b1;
    read_all(1'b1);

    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised multi-channel successor to the single-channel Timer0 peripheral.
- NUM_CH independent up-counters, each with:
  - prescaler
  - auto-reload
  - one-shot / periodic mode
  - W1C update flag
  - interrupt enable
- Slave on the BusMatrix with a write port and a read port (the latter new in this generation).
- Drives a combined interrupt line to the Core plus a per-channel vector.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, width of PSC/ARR/CNT registers (8..32).
- BASE_ADDR, 64'h5000_0000, base address of channel 0.
- CH_STRIDE, 64'h20, address stride between channels.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- WriteValid  in  1  write request, qualified by address/data/strobe
- WriteAddr  in  64  write byte address
- WriteData  in  64  write data; bits [31:0] used
- WriteStrb  in  4  byte enables for WriteData[31:0]
- SlaverWriteReady  out  1  one-cycle write acknowledge
- ReadValid  in  1  read request
- ReadAddr  in  64  read byte address
- ReadData  out  64  read data; zero-extended from 32 bits
- SlaverReadReady  out  1  one-cycle read acknowledge, ReadData valid
- TimerIrq  out  NUM_CH  per-channel interrupt, SR.UIF & CR.UIE
- TimerInt  out  1  OR of TimerIrq

Behaviour:
- Reset (ARESETn low at a rising ACLK edge):
  - All registers and internal prescaler counters are 0.
  - Both Ready outputs and ReadData are 0.
  - Reset mid-count aborts immediately.
- Register map, at BASE_ADDR + ch*CH_STRIDE + offset:
  - 0x00 CR: bit0 EN, bit1 OPM (one-shot), bit2 UIE.
  - 0x04 PSC.
  - 0x08 ARR.
  - 0x0C CNT: read/write, a write loads the counter.
  - 0x10 SR: bit0 UIF, write-1-to-clear.
  - Fields are CNT_W bits; upper bits read 0 and ignore writes.
- Write:
  - A write is accepted in any cycle with WriteValid=1.
  - Byte lanes are applied per WriteStrb.
  - SlaverWriteReady=1 in the following cycle, for exactly one cycle.
  - Writes to unmapped or ch>=NUM_CH addresses are discarded but still acknowledged.
  - Back-to-back writes are allowed, one per cycle.
- Read:
  - ReadValid=1 samples ReadAddr.
  - Next cycle: SlaverReadReady=1 and ReadData = register value at the sample edge.
  - Unmapped addresses read 0.
  - A read and a write in the same cycle are both serviced. A read of the register being written returns the old value.
- Counting, per channel, when CR.EN=1:
  - The prescaler counter increments each cycle.
  - When it equals PSC it returns to 0 and issues a tick, so the tick period is PSC+1 cycles.
  - On a tick with CNT==ARR: CNT<=0, UIF<=1. If OPM=1, EN<=0 in the same cycle.
  - Otherwise, on a tick, CNT<=CNT+1 (wraps at 2^CNT_W).
  - Update period = (PSC+1)*(ARR+1) cycles. PSC=0, ARR=0 raises UIF every cycle.
- EN=0:
  - CNT and the prescaler counter hold.
  - Setting EN again resumes from the held values.
- Software writes:
  - A write to PSC or CNT clears the prescaler counter.
  - Writing ARR below the current CNT: CNT counts up to wrap, then matches ARR.
- Simultaneous events:
  - Hardware UIF set in the same cycle as a W1C clear: UIF=1 (set wins).
  - CNT write in the same cycle as a tick: the written value wins and no update event occurs.
  - CR write in the same cycle as an OPM auto-clear: the written value wins.
- Interrupts:
  - TimerIrq[ch] is combinational from the register state: UIF & UIE.
  - TimerInt = |TimerIrq.
  - UIF is set regardless of UIE. Clearing UIE masks the output but does not clear UIF.

Test Plan:
- Reset, then read every register of all channels -> all reads 0, SlaverReadReady pulses 1 cycle after each ReadValid, TimerInt=0.
- ch0: PSC=0, ARR=4, CR=0x5 -> UIF rises every 5 cycles. TimerIrq[0]=1 after the first update. Write SR=1 -> UIF clears next cycle and re-sets 5 cycles after the previous update.
- ch1: PSC=3, ARR=2, CR=0x3 (OPM) -> single UIF after 12 cycles. CR reads 0x2, CNT stays 0 thereafter, TimerIrq[1]=0 (UIE=0).
- ch2: PSC=0, ARR=0, CR=1. Issue SR=1 every cycle -> UIF reads 1 continuously (set wins).
- ch3: ARR=10, CR=1, counting. At CNT=6 write CNT=9 -> update occurs 2 ticks later. Clear EN at CNT=3 -> CNT holds at 3 for 20 cycles.
- Write 0xFFFF_FFFF with WriteStrb=0x1 to ch0 ARR -> ARR reads 0x0000_00FF. Write to BASE_ADDR+NUM_CH*0x20 -> acknowledged, no register changes.
